// File: rtl/neuron_mac.sv
// Multiply-accumulate neuron stage: streams pairs into the external mult, accumulates
// the products on top of a signed bias, then applies ReLU, shift and 8-bit clamp.
module neuron_mac #(
  parameter int N_INPUTS = 784,
  parameter int ACC_W    = 32,
  parameter int SHIFT    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ACC_W-1:0] bias,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic [7:0]       op_a,
  output logic [7:0]       op_b,
  input  logic [15:0]      p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             busy,
  output logic             ovf
);

  localparam int CNT_W = $clog2(N_INPUTS + 1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] OUT_MAX = ACC_W'(255);

  typedef enum logic [1:0] {IDLE, ACCUM, FINAL, DONE} state_t;

  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [7:0]              out_data_q, out_data_d;
  logic                    ovf_q, ovf_d;

  logic signed [ACC_W:0]   sum_ext;
  logic signed [ACC_W-1:0] shifted;

  assign op_a      = in_a;
  assign op_b      = in_b;
  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = out_data_q;
  assign ovf       = ovf_q;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    count_d    = count_q;
    out_data_d = out_data_q;
    ovf_d      = ovf_q;
    // One guard bit: products are non-negative, so only positive overflow can occur.
    sum_ext    = {acc_q[ACC_W-1], acc_q} + {1'b0, {(ACC_W-16){1'b0}}, p};
    shifted    = acc_q >>> SHIFT;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d   = bias;
          count_d = '0;
          ovf_d   = 1'b0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          if (sum_ext[ACC_W] != sum_ext[ACC_W-1]) begin
            acc_d = ACC_MAX;
            ovf_d = 1'b1;
          end else begin
            acc_d = sum_ext[ACC_W-1:0];
          end
          count_d = count_q + CNT_W'(1);
          if (count_q == CNT_W'(N_INPUTS - 1)) state_d = FINAL;
        end
      end
      FINAL: begin
        if (acc_q[ACC_W-1])        out_data_d = 8'd0;
        else if (shifted > OUT_MAX) out_data_d = 8'hFF;
        else                       out_data_d = shifted[7:0];
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      count_q    <= '0;
      out_data_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      out_data_q <= out_data_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_neuron_mac.sv
// Bench for neuron_mac: three instances (SHIFT=2, SHIFT=0, ACC_W=18/SHIFT=10) share stimulus;
// a behavioural model fills per-instance scoreboards that are drained when results appear.
module tb_neuron_mac;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_a = 8'h00;
  logic [7:0]  in_b = 8'h00;
  logic        out_ready = 1'b0;
  logic [31:0] bias_w = '0;
  logic [17:0] bias_n = '0;

  logic        in_ready_a, out_valid_a, busy_a, ovf_a;
  logic        in_ready_b, out_valid_b, busy_b, ovf_b;
  logic        in_ready_c, out_valid_c, busy_c, ovf_c;
  logic [7:0]  op_a_a, op_b_a, op_a_b, op_b_b, op_a_c, op_b_c;
  logic [7:0]  out_data_a, out_data_b, out_data_c;
  logic [15:0] p_a, p_b, p_c;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  vec_a [N];
  logic [7:0]  vec_b [N];
  int unsigned pair_prod [$];
  logic [8:0]  exp_a [$];
  logic [8:0]  exp_b [$];
  logic [8:0]  exp_c [$];

  always #5 clk = ~clk;

  // Combinational 8x8 multiplier stand-ins, fed from each DUT's operand outputs.
  assign p_a = {8'h00, op_a_a} * {8'h00, op_b_a};
  assign p_b = {8'h00, op_a_b} * {8'h00, op_b_b};
  assign p_c = {8'h00, op_a_c} * {8'h00, op_b_c};

  neuron_mac #(.N_INPUTS(N), .ACC_W(32), .SHIFT(2)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .bias(bias_w), .in_valid(in_valid),
    .in_ready(in_ready_a), .in_a(in_a), .in_b(in_b), .op_a(op_a_a), .op_b(op_b_a),
    .p(p_a), .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a),
    .busy(busy_a), .ovf(ovf_a));

  neuron_mac #(.N_INPUTS(N), .ACC_W(32), .SHIFT(0)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .bias(bias_w), .in_valid(in_valid),
    .in_ready(in_ready_b), .in_a(in_a), .in_b(in_b), .op_a(op_a_b), .op_b(op_b_b),
    .p(p_b), .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .busy(busy_b), .ovf(ovf_b));

  neuron_mac #(.N_INPUTS(N), .ACC_W(18), .SHIFT(10)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start), .bias(bias_n), .in_valid(in_valid),
    .in_ready(in_ready_c), .in_a(in_a), .in_b(in_b), .op_a(op_a_c), .op_b(op_b_c),
    .p(p_c), .out_valid(out_valid_c), .out_ready(out_ready), .out_data(out_data_c),
    .busy(busy_c), .ovf(ovf_c));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference result {ovf, data} for the pairs recorded in pair_prod.
  function automatic logic [8:0] model_result(input longint bias_v, input int accw, input int shift);
    longint acc = bias_v;
    longint mx  = (longint'(1) <<< (accw - 1)) - 1;
    bit     ov  = 1'b0;
    logic [7:0] d;
    foreach (pair_prod[i]) begin
      acc = acc + longint'(pair_prod[i]);
      if (acc > mx) begin
        acc = mx;
        ov  = 1'b1;
      end
    end
    if (acc < 0)                 d = 8'h00;
    else if ((acc >>> shift) > 255) d = 8'hFF;
    else                         d = 8'(acc >>> shift);
    return {ov, d};
  endfunction

  task automatic set_vectors(input logic [31:0] a4, input logic [31:0] b4);
    for (int i = 0; i < N; i++) begin
      vec_a[i] = a4[8*i +: 8];
      vec_b[i] = b4[8*i +: 8];
    end
  endtask

  // Starts a neuron and feeds N pairs; valid_pat bit k is in_valid for cycle k.
  task automatic applyStimulus(input longint bias_v, input logic [15:0] valid_pat,
                               input int stop_after, input bit push_exp);
    int idx = 0;
    int cyc = 0;
    bias_w = 32'(bias_v);
    bias_n = 18'(bias_v);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pair_prod.delete();
    while (idx < stop_after && cyc < 50) begin
      in_valid = (cyc < 16) ? valid_pat[cyc] : 1'b1;
      in_a = vec_a[idx];
      in_b = vec_b[idx];
      if (in_valid && in_ready_a) begin
        pair_prod.push_back(int'(vec_a[idx]) * int'(vec_b[idx]));
        idx++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    check("pairs_accepted", idx, stop_after);
    if (push_exp) begin
      exp_a.push_back(model_result(bias_v, 32, 2));
      exp_b.push_back(model_result(bias_v, 32, 0));
      exp_c.push_back(model_result(bias_v, 18, 10));
    end
  endtask

  // Waits for the result, scores all instances, optionally stalls and pokes start.
  task automatic checkOutput(input int hold, input bit poke_start, input int exp_lat);
    int wait_cnt = 0;
    logic [8:0] ea, eb, ec;
    while (!out_valid_a && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    check("out_valid_a", out_valid_a, 1);
    check("out_valid_bc", {out_valid_b, out_valid_c}, 2'b11);
    if (exp_lat > 0) check("latency", wait_cnt + 1, exp_lat);
    if (exp_a.size() == 0 || exp_b.size() == 0 || exp_c.size() == 0) begin
      check("scoreboard_nonempty", 0, 1);
    end else begin
      ea = exp_a.pop_front();
      eb = exp_b.pop_front();
      ec = exp_c.pop_front();
      check("data_a", out_data_a, ea[7:0]);
      check("ovf_a", ovf_a, ea[8]);
      check("data_b", out_data_b, eb[7:0]);
      check("ovf_b", ovf_b, eb[8]);
      check("data_c", out_data_c, ec[7:0]);
      check("ovf_c", ovf_c, ec[8]);
      for (int k = 0; k < hold; k++) begin
        start = poke_start && (k == 2);
        @(negedge clk);
        start = 1'b0;
        check("hold_valid", out_valid_a, 1);
        check("hold_data", out_data_a, ea[7:0]);
      end
    end
    out_ready = 1'b1;
    start = poke_start;
    @(negedge clk);
    out_ready = 1'b0;
    start = 1'b0;
    check("idle_after_xfer", {busy_a, busy_b, busy_c, out_valid_a}, 4'b0000);
    if (poke_start) begin
      @(negedge clk);
      check("start_on_xfer_ignored", busy_a, 0);
    end
  endtask

  initial begin
    $display("[TB] neuron_mac bench starting");
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_state_a", {busy_a, in_ready_a, out_valid_a, ovf_a, out_data_a}, 12'h000);
    check("rst_state_c", {busy_c, in_ready_c, out_valid_c, ovf_c, out_data_c}, 12'h000);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_start", busy_a, 0);

    // Operand pass-through is combinational regardless of in_ready.
    in_a = 8'hA5;
    in_b = 8'h3C;
    #1;
    check("op_passthrough", {op_a_a, op_b_a}, 16'hA53C);

    // Scenario 1/2: basic result, with SHIFT=0 clipping in u_b.
    set_vectors(32'h04030201, 32'h40302010);
    applyStimulus(0, 16'hFFFF, N, 1'b1);
    checkOutput(0, 1'b0, 2);

    // Scenario 3: ReLU with negative bias.
    applyStimulus(-1000, 16'hFFFF, N, 1'b1);
    checkOutput(0, 1'b0, 0);

    // Scenario 4: accumulator saturation in the 18-bit instance.
    set_vectors(32'hFFFFFFFF, 32'hFFFFFFFF);
    applyStimulus(0, 16'hFFFF, N, 1'b1);
    checkOutput(0, 1'b0, 0);

    // Scenario 5: input bubbles 1,0,0,1,1,0,1 then output backpressure with stray starts.
    set_vectors(32'h04030201, 32'h40302010);
    applyStimulus(0, 16'b0000_0000_0101_1001, N, 1'b1);
    checkOutput(5, 1'b1, 0);

    // Scenario 6: reset after two accepted pairs abandons the neuron.
    applyStimulus(0, 16'hFFFF, 2, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_a", {busy_a, in_ready_a, out_valid_a}, 3'b000);
    check("midrst_c", {busy_c, in_ready_c, out_valid_c}, 3'b000);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("no_partial_result", out_valid_a, 0);
    applyStimulus(0, 16'hFFFF, N, 1'b1);
    checkOutput(0, 1'b0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
